// File: rtl/mpsubtractor_serial.sv
`default_nettype none
// ============================================================================
// Module      : mpsubtractor_serial
// Description : Limb-serial multi-precision subtractor producing
//               {sign, (in_a - in_b) mod 2^WIDTH} over one limb per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mpsubtractor_serial #(
    parameter int WIDTH = 1027,
    parameter int LIMB  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

    localparam int NLIMBS = (WIDTH + LIMB - 1) / LIMB;
    localparam int PADW   = NLIMBS * LIMB;
    localparam int CNTW   = $clog2(NLIMBS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PADW-1:0] a_q, a_d;
    logic [PADW-1:0] b_q, b_d;
    logic [PADW-1:0] diff_q, diff_d;
    logic            borrow_q, borrow_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]  result_q, result_d;

    logic            w_load;
    logic            w_last;
    logic [LIMB:0]   w_sub;
    logic [PADW-1:0] w_diff_shift;

    // Start is honoured only outside RUN, so a stray start mid-operation is harmless
    assign w_load       = start && (state_q != S_RUN);
    assign w_last       = (state_q == S_RUN) && (cnt_q == CNTW'(NLIMBS - 1));
    assign w_sub        = {1'b0, a_q[LIMB-1:0]} - {1'b0, b_q[LIMB-1:0]}
                        - {{LIMB{1'b0}}, borrow_q};
    assign w_diff_shift = {w_sub[LIMB-1:0], diff_q[PADW-1:LIMB]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (w_last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_RUN);
        done   = (state_q == S_DONE);
        result = result_q;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (w_load) begin
            a_d      = PADW'(in_a);
            b_d      = PADW'(in_b);
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == S_RUN) begin
            a_d      = {{LIMB{1'b0}}, a_q[PADW-1:LIMB]};
            b_d      = {{LIMB{1'b0}}, b_q[PADW-1:LIMB]};
            diff_d   = w_diff_shift;
            borrow_d = w_sub[LIMB];
            cnt_d    = cnt_q + CNTW'(1);
            // Pad bits above WIDTH carry the sign when in_a < in_b
            if (w_last) begin
                result_d = {w_sub[LIMB] | (|(w_diff_shift >> WIDTH)),
                            w_diff_shift[WIDTH-1:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire
